// File: rtl/huffman_decode.sv
// Huffman tree walker: consumes one encoded bit per node step, emits one 8-bit symbol per leaf.
// Latency: 4 cycles per bit (WAIT_BIT, RD_FLAG, RD_VAL, LAT_VAL); symbol valid the cycle after a leaf LAT_VAL.
// Backpressure: bit_ready only in WAIT_BIT; sym_out held stable while sym_ready low. Optional checks: HUFF_DEC_ERRCHK_EN.
module huffman_decode #(
    parameter logic [15:0] TREE_BASE = 16'h0400,
    parameter int          MAX_DEPTH = 255
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        DEC_start,
    input  logic [15:0] num_symbols,
    output logic        DEC_finish,
    output logic        DEC_error,
    input  logic        bit_in,
    input  logic        bit_valid,
    output logic        bit_ready,
    output logic [7:0]  sym_out,
    output logic        sym_valid,
    input  logic        sym_ready,
    output logic        mem_R,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_data_R
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BIT,
        S_RD_FLAG,
        S_RD_VAL,
        S_LAT_VAL,
        S_EMIT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  node_q, node_d;
    logic        bit_q, bit_d;
    logic        flag_q, flag_d;
    logic [7:0]  sym_d;
    logic [15:0] count_q, count_d;
    logic [15:0] num_q, num_d;
    // Zero-length jobs spend one settle cycle in DONE so the finish pulse
    // lands two cycles after the start pulse.
    logic        hold_q, hold_d;

    logic [15:0] addr_flag;
    logic [15:0] addr_val;
    logic [15:0] count_inc;

`ifdef HUFF_DEC_ERRCHK_EN
    logic        err_q, err_d;
    logic [7:0]  depth_q, depth_d;
    logic [8:0]  depth_inc;

    assign depth_inc = {1'b0, depth_q} + 9'd1;
    assign DEC_error = err_q;
`else
    assign DEC_error = 1'b0;
`endif

    // Byte address of the flag for the current (node, bit) pair; wraps at 16 bits.
    assign addr_flag = TREE_BASE + {6'd0, node_q, 2'b00} + {14'd0, bit_q, 1'b0};
    assign addr_val  = addr_flag + 16'd1;
    assign count_inc = count_q + 16'd1;

    // State and datapath registers; async reset discards any partial walk.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            node_q  <= 8'h00;
            bit_q   <= 1'b0;
            flag_q  <= 1'b0;
            sym_out <= 8'h00;
            count_q <= 16'h0000;
            num_q   <= 16'h0000;
            hold_q  <= 1'b0;
`ifdef HUFF_DEC_ERRCHK_EN
            err_q   <= 1'b0;
            depth_q <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            node_q  <= node_d;
            bit_q   <= bit_d;
            flag_q  <= flag_d;
            sym_out <= sym_d;
            count_q <= count_d;
            num_q   <= num_d;
            hold_q  <= hold_d;
`ifdef HUFF_DEC_ERRCHK_EN
            err_q   <= err_d;
            depth_q <= depth_d;
`endif
        end
    end

    // Next-state, next-datapath and handshake/memory outputs.
    always_comb begin
        state_d    = state_q;
        node_d     = node_q;
        bit_d      = bit_q;
        flag_d     = flag_q;
        sym_d      = sym_out;
        count_d    = count_q;
        num_d      = num_q;
        hold_d     = hold_q;
`ifdef HUFF_DEC_ERRCHK_EN
        err_d      = err_q;
        depth_d    = depth_q;
`endif
        bit_ready  = 1'b0;
        sym_valid  = 1'b0;
        mem_R      = 1'b0;
        mem_addr   = 16'h0000;
        DEC_finish = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (DEC_start) begin
                    num_d   = num_symbols;
                    count_d = 16'h0000;
                    node_d  = 8'h00;
`ifdef HUFF_DEC_ERRCHK_EN
                    err_d   = 1'b0;
                    depth_d = 8'h00;
`endif
                    if (num_symbols == 16'h0000) begin
                        state_d = S_DONE;
                        hold_d  = 1'b1;
                    end else begin
                        state_d = S_WAIT_BIT;
                    end
                end
            end

            S_WAIT_BIT: begin
                bit_ready = 1'b1;
                if (bit_valid) begin
                    bit_d   = bit_in;
                    state_d = S_RD_FLAG;
                end
            end

            S_RD_FLAG: begin
                mem_R    = 1'b1;
                mem_addr = addr_flag;
                state_d  = S_RD_VAL;
            end

            S_RD_VAL: begin
                mem_R    = 1'b1;
                mem_addr = addr_val;
                flag_d   = mem_data_R[0];
                state_d  = S_LAT_VAL;
`ifdef HUFF_DEC_ERRCHK_EN
                // Only bit0 of a flag byte carries meaning; anything else is a corrupt tree.
                if (mem_data_R[7:1] != 7'd0) begin
                    err_d   = 1'b1;
                    node_d  = 8'h00;
                    depth_d = 8'h00;
                    state_d = S_DONE;
                end
`endif
            end

            S_LAT_VAL: begin
                if (flag_q) begin
                    sym_d   = mem_data_R;
                    node_d  = 8'h00;
`ifdef HUFF_DEC_ERRCHK_EN
                    depth_d = 8'h00;
`endif
                    state_d = S_EMIT;
                end else begin
                    node_d  = mem_data_R;
                    state_d = S_WAIT_BIT;
`ifdef HUFF_DEC_ERRCHK_EN
                    depth_d = depth_inc[7:0];
                    // A walk this deep means the tree loops or is malformed.
                    if (int'(depth_inc) >= MAX_DEPTH) begin
                        err_d   = 1'b1;
                        node_d  = 8'h00;
                        depth_d = 8'h00;
                        state_d = S_DONE;
                    end
`endif
                end
            end

            S_EMIT: begin
                sym_valid = 1'b1;
                if (sym_ready) begin
                    count_d = count_inc;
                    if (count_inc == num_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT_BIT;
                    end
                end
            end

            S_DONE: begin
                if (hold_q) begin
                    hold_d = 1'b0;
                end else begin
                    DEC_finish = 1'b1;
                    state_d    = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_huffman_decode.sv
module tb_huffman_decode;

    logic        clk;
    logic        n_rst;

    logic        dec_start;
    logic [15:0] num_symbols;
    logic        dec_finish;
    logic        dec_error;
    logic        bit_in;
    logic        bit_valid;
    logic        bit_ready;
    logic [7:0]  sym_out;
    logic        sym_valid;
    logic        sym_ready;
    logic        mem_r;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;

    logic        w_start;
    logic [15:0] w_num;
    logic        w_finish;
    logic        w_error;
    logic        w_bit_in;
    logic        w_bit_valid;
    logic        w_bit_ready;
    logic [7:0]  w_sym_out;
    logic        w_sym_valid;
    logic        w_sym_ready;
    logic        w_mem_r;
    logic [15:0] w_mem_addr;
    logic [7:0]  w_mem_data;

    logic [7:0]  mem [0:65535];

    int tests = 0;
    int fails = 0;

    huffman_decode dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .DEC_start   (dec_start),
        .num_symbols (num_symbols),
        .DEC_finish  (dec_finish),
        .DEC_error   (dec_error),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .bit_ready   (bit_ready),
        .sym_out     (sym_out),
        .sym_valid   (sym_valid),
        .sym_ready   (sym_ready),
        .mem_R       (mem_r),
        .mem_addr    (mem_addr),
        .mem_data_R  (mem_data)
    );

    huffman_decode #(.TREE_BASE(16'hFFFC)) dut_w (
        .clk         (clk),
        .n_rst       (n_rst),
        .DEC_start   (w_start),
        .num_symbols (w_num),
        .DEC_finish  (w_finish),
        .DEC_error   (w_error),
        .bit_in      (w_bit_in),
        .bit_valid   (w_bit_valid),
        .bit_ready   (w_bit_ready),
        .sym_out     (w_sym_out),
        .sym_valid   (w_sym_valid),
        .sym_ready   (w_sym_ready),
        .mem_R       (w_mem_r),
        .mem_addr    (w_mem_addr),
        .mem_data_R  (w_mem_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM model: read data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_r)   mem_data   <= mem[mem_addr];
        if (w_mem_r) w_mem_data <= mem[w_mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        int n = 0;
        while (!bit_ready && n < 40) begin
            tick();
            n++;
        end
        chk1("bit_ready_wait", bit_ready, 1'b1);
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic wait_sym();
        int n = 0;
        while (!sym_valid && n < 40) begin
            tick();
            n++;
        end
        chk1("sym_valid_wait", sym_valid, 1'b1);
    endtask

    initial begin
        int   consumes;
        int   n;
        logic seen_fin;
        logic seen_vld;

        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'h0400] = 8'h01; mem[16'h0401] = 8'h41;
        mem[16'h0402] = 8'h00; mem[16'h0403] = 8'h01;
        mem[16'h0404] = 8'h01; mem[16'h0405] = 8'h42;
        mem[16'h0406] = 8'h01; mem[16'h0407] = 8'h43;
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h01;
        mem[16'h0000] = 8'h01; mem[16'h0001] = 8'h55;

        n_rst = 1'b0;
        dec_start = 1'b0; num_symbols = 16'd0; bit_in = 1'b0; bit_valid = 1'b0; sym_ready = 1'b0;
        w_start = 1'b0; w_num = 16'd0; w_bit_in = 1'b0; w_bit_valid = 1'b0; w_sym_ready = 1'b0;

        // Reset values
        tick(); tick();
        chk1("rst_bit_ready", bit_ready, 1'b0);
        chk1("rst_sym_valid", sym_valid, 1'b0);
        chk1("rst_mem_r", mem_r, 1'b0);
        chk1("rst_finish", dec_finish, 1'b0);
        chk1("rst_error", dec_error, 1'b0);
        chk8("rst_sym_out", sym_out, 8'h00);
        chk16("rst_mem_addr", mem_addr, 16'h0000);
        n_rst = 1'b1;
        tick();
        chk1("idle_bit_ready", bit_ready, 1'b0);

        // Decode 3 symbols from bits 0,1,0,1,1
        dec_start = 1'b1; num_symbols = 16'd3;
        tick();
        dec_start = 1'b0;
        chk1("first_bit_ready", bit_ready, 1'b1);
        bit_valid = 1'b1; bit_in = 1'b0;
        tick();
        bit_valid = 1'b0;
        chk1("rdflag_mem_r", mem_r, 1'b1);
        chk16("rdflag_addr", mem_addr, 16'h0400);
        tick();
        chk1("rdval_mem_r", mem_r, 1'b1);
        chk16("rdval_addr", mem_addr, 16'h0401);
        tick();
        chk1("latval_mem_r", mem_r, 1'b0);
        chk16("latval_addr", mem_addr, 16'h0000);
        chk1("latval_sym_valid", sym_valid, 1'b0);
        tick();
        chk1("emit_sym_valid", sym_valid, 1'b1);
        chk8("sym0", sym_out, 8'h41);

        // Backpressure for 5 cycles; a start pulse mid-job must be ignored
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                dec_start = 1'b1; num_symbols = 16'd0;
            end
            tick();
            dec_start = 1'b0; num_symbols = 16'd3;
            chk1("bp_sym_valid", sym_valid, 1'b1);
            chk8("bp_sym_out", sym_out, 8'h41);
            chk1("bp_bit_ready", bit_ready, 1'b0);
            chk1("bp_finish", dec_finish, 1'b0);
        end
        sym_ready = 1'b1;
        tick();
        sym_ready = 1'b0;
        chk1("resume_bit_ready", bit_ready, 1'b1);
        chk1("resume_sym_valid", sym_valid, 1'b0);

        send_bit(1'b1);
        send_bit(1'b0);
        wait_sym();
        chk8("sym1", sym_out, 8'h42);
        sym_ready = 1'b1;
        tick();
        sym_ready = 1'b0;

        // bit_valid held high: one bit per WAIT_BIT visit, two visits to reach 0x43
        bit_valid = 1'b1; bit_in = 1'b1;
        consumes = 0; n = 0;
        while (!sym_valid && n < 40) begin
            if (bit_ready) consumes++;
            tick();
            n++;
        end
        bit_valid = 1'b0;
        chk8("hold_consumes", 8'(consumes), 8'd2);
        chk1("sym2_valid", sym_valid, 1'b1);
        chk8("sym2", sym_out, 8'h43);
        sym_ready = 1'b1;
        tick();
        sym_ready = 1'b0;
        chk1("finish_after_last", dec_finish, 1'b1);
        tick();
        chk1("finish_one_cycle", dec_finish, 1'b0);
        chk1("idle_after_done", bit_ready, 1'b0);

        // Zero-length job
        dec_start = 1'b1; num_symbols = 16'd0;
        tick();
        dec_start = 1'b0;
        chk1("zero_finish_c1", dec_finish, 1'b0);
        chk1("zero_mem_r_c1", mem_r, 1'b0);
        tick();
        chk1("zero_finish_c2", dec_finish, 1'b1);
        chk1("zero_mem_r_c2", mem_r, 1'b0);
        tick();
        chk1("zero_finish_c3", dec_finish, 1'b0);

        // Reset in RD_VAL while walking node 1, then restart from node 0
        dec_start = 1'b1; num_symbols = 16'd1;
        tick();
        dec_start = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);
        chk16("node1_flag_addr", mem_addr, 16'h0406);
        tick();
        chk16("node1_val_addr", mem_addr, 16'h0407);
        #2 n_rst = 1'b0;
        #1;
        chk1("arst_mem_r", mem_r, 1'b0);
        chk16("arst_mem_addr", mem_addr, 16'h0000);
        chk8("arst_sym_out", sym_out, 8'h00);
        chk1("arst_bit_ready", bit_ready, 1'b0);
        chk1("arst_sym_valid", sym_valid, 1'b0);
        tick();
        n_rst = 1'b1;
        tick();
        dec_start = 1'b1; num_symbols = 16'd1;
        tick();
        dec_start = 1'b0;
        send_bit(1'b0);
        wait_sym();
        chk8("restart_sym", sym_out, 8'h41);
        sym_ready = 1'b1;
        tick();
        sym_ready = 1'b0;
        chk1("restart_finish", dec_finish, 1'b1);
        tick();

        // Address wrap with TREE_BASE = 0xFFFC
        w_start = 1'b1; w_num = 16'd1;
        tick();
        w_start = 1'b0;
        chk1("wrap_bit_ready0", w_bit_ready, 1'b1);
        w_bit_valid = 1'b1; w_bit_in = 1'b0;
        tick();
        w_bit_valid = 1'b0;
        chk16("wrap_root_flag", w_mem_addr, 16'hFFFC);
        tick();
        chk16("wrap_root_val", w_mem_addr, 16'hFFFD);
        tick();
        tick();
        chk1("wrap_bit_ready1", w_bit_ready, 1'b1);
        w_bit_valid = 1'b1; w_bit_in = 1'b0;
        tick();
        w_bit_valid = 1'b0;
        chk1("wrap_node1_mem_r", w_mem_r, 1'b1);
        chk16("wrap_node1_flag", w_mem_addr, 16'h0000);
        tick();
        chk16("wrap_node1_val", w_mem_addr, 16'h0001);
        tick();
        tick();
        chk1("wrap_sym_valid", w_sym_valid, 1'b1);
        chk8("wrap_sym", w_sym_out, 8'h55);
        w_sym_ready = 1'b1;
        tick();
        w_sym_ready = 1'b0;
        chk1("wrap_finish", w_finish, 1'b1);
        tick();

`ifdef HUFF_DEC_ERRCHK_EN
        // Corrupt flag byte aborts the job with an error
        mem[16'h0400] = 8'h80;
        dec_start = 1'b1; num_symbols = 16'd1;
        tick();
        dec_start = 1'b0;
        send_bit(1'b0);
        seen_fin = 1'b0; seen_vld = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (dec_finish) seen_fin = 1'b1;
            if (sym_valid)  seen_vld = 1'b1;
        end
        chk1("err_finish_seen", seen_fin, 1'b1);
        chk1("err_no_symbol", seen_vld, 1'b0);
        chk1("err_flag", dec_error, 1'b1);
        mem[16'h0400] = 8'h01;
        dec_start = 1'b1; num_symbols = 16'd0;
        tick();
        dec_start = 1'b0;
        chk1("err_clear_on_start", dec_error, 1'b0);
        tick();
        tick();
`else
        seen_fin = 1'b0; seen_vld = 1'b0;
        chk1("error_tied_low", dec_error, 1'b0);
        chk1("wrap_error_tied_low", w_error, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/huffman_decode.md
# huffman_decode

Reads a Huffman tree that build-tree and code-transform left in on-chip SRAM, then walks it one input bit at a time. Each leaf reached emits one decoded 8-bit symbol. It is the receive-side counterpart of the encoder path. It shares the SRAM read port through the BTCT-style controller mux and runs between `DEC_start` and `DEC_finish`.

## Interface
Parameters:
- `TREE_BASE`, default 16'h0400: SRAM byte address of tree node 0 (the root).
- `MAX_DEPTH`, default 255: walk-depth limit; used only when error checking is compiled in.

Ports:
- `clk`, in, 1: the block's single clock.
- `n_rst`, in, 1: reset, asynchronous, active-low.
- `DEC_start`, in, 1: one-cycle start pulse; ignored unless in IDLE.
- `num_symbols`, in, 16: number of symbols to decode; sampled on accepted `DEC_start`.
- `DEC_finish`, out, 1: one-cycle done pulse.
- `DEC_error`, out, 1: sticky error flag.
- `bit_in`, in, 1: encoded bit.
- `bit_valid`, in, 1: `bit_in` is valid.
- `bit_ready`, out, 1: block will accept a bit this cycle.
- `sym_out`, out, 8: decoded symbol.
- `sym_valid`, out, 1: `sym_out` is valid.
- `sym_ready`, in, 1: downstream accepts the symbol.
- `mem_R`, out, 1: SRAM read enable. The block never writes SRAM.
- `mem_addr`, out, 16: SRAM byte address.
- `mem_data_R`, in, 8: SRAM read data, valid in the cycle after `mem_R`.

## Operation
- Tree format:
  - Node n occupies 4 bytes at TREE_BASE+4n.
  - Offset +0 is the flag for bit 0; +1 is the value for bit 0.
  - Offset +2 is the flag for bit 1; +3 is the value for bit 1.
  - Flag bit0=1 means leaf, and the value is the symbol.
  - Flag bit0=0 means internal node, and the value is the child node index (0..255).
- Address arithmetic: A = TREE_BASE + {node,2'b00} + {bit,1'b0}, computed at 16 bits and wrapping mod 2^16.
- States:
  - IDLE → (`DEC_start`) → DONE if `num_symbols`==0; otherwise WAIT_BIT.
  - WAIT_BIT: `bit_ready`=1. On `bit_valid`, latch the bit → RD_FLAG.
  - RD_FLAG: `mem_R`=1, `mem_addr`=A → RD_VAL.
  - RD_VAL: `mem_R`=1, `mem_addr`=A+1; capture the flag from `mem_data_R` → LAT_VAL.
  - LAT_VAL: capture the value.
    - Leaf: load `sym_out`, reset node to 0 and depth to 0 → EMIT.
    - Internal: node ← value, depth+1 → WAIT_BIT.
  - EMIT: `sym_valid`=1 and `sym_out` held stable until `sym_ready`. On handshake, count+1; if count==`num_symbols` → DONE, else → WAIT_BIT.
  - DONE: `DEC_finish`=1 for one cycle → IDLE.
- The symbol counter is 16 bits, and the comparison is exact.
- Every walk starts at node 0.
- `DEC_start` outside IDLE has no effect.
- `DEC_error` clears on an accepted `DEC_start`.

## Timing
- Reset values:
  - State IDLE.
  - `bit_ready`, `sym_valid`, `mem_R`, `DEC_finish`, `DEC_error` = 0.
  - `sym_out` = 8'h00, `mem_addr` = 16'h0000.
  - Node, depth and count = 0.
- An asynchronous reset mid-operation returns to IDLE immediately and discards any partial walk.
- Cost per bit: 4 cycles minimum (WAIT_BIT, RD_FLAG, RD_VAL, LAT_VAL).
- Leaf bit: `sym_valid` rises in the cycle after LAT_VAL.
- From the `DEC_start` cycle, the first `bit_ready` is asserted on the next cycle.
- A `bit_valid` held high is consumed once per WAIT_BIT visit.
- `mem_addr` is 0 whenever `mem_R`=0.
- `DEC_finish` asserts the cycle after the final `sym_ready` handshake.
- `num_symbols`=0: `DEC_finish` asserts 2 cycles after `DEC_start`, with no memory reads.

## Configuration
- `HUFF_DEC_ERRCHK_EN` defined:
  - In RD_VAL, a flag byte with bits[7:1] ≠ 0 is an error.
  - Reaching depth==`MAX_DEPTH` at an internal node is an error.
  - On error: `DEC_error`←1, jump to DONE (`DEC_finish` pulses), and no symbol is emitted.
- Not defined:
  - `DEC_error` is tied to 0.
  - Only flag bit0 is examined.
  - Depth is not tracked.

## Test plan
- Tree setup: memory 0x0400–0x0407 = 01 41 00 01 01 42 01 43; `num_symbols`=3; bits 0,1,0,1,1 → symbols 0x41, 0x42, 0x43, then a `DEC_finish` pulse.
- Backpressure: same tree, `sym_ready` low for 5 cycles during EMIT → `sym_out`=0x41 stays stable, `bit_ready` stays 0, decoding resumes after the handshake.
- `num_symbols`=0 → `DEC_finish` 2 cycles after start, `mem_R` never asserted.
- Reset asserted in RD_VAL → all outputs return to reset values immediately. A restart then decodes 0x41 correctly from node 0.
- With `HUFF_DEC_ERRCHK_EN`: flag byte 0x80 at 0x0400 and bit 0 → `DEC_error`=1, `DEC_finish` pulses, `sym_valid` never asserts.
- `TREE_BASE`=16'hFFFC, node 1 → `mem_addr` wraps to 0x0000/0x0001 for bit 0.
